// File: rtl/upower_fetch_unit_if.sv
// Fetch-unit bus bundle: imem req/ack, execute redirect, decode valid/ready.
// master is the fetch unit side, slave is the memory/execute/decode environment.
interface upower_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/upower_fetch_unit.sv
// uPower fetch: PC + imem req/ack into a FIFO_DEPTH prefetch FIFO, 1 cycle ack->inst_valid, redirect flushes.
// Issue stalls while the FIFO has no room (inst_ready backpressure); FETCH_PERF_CNT_EN adds perf counters.
module upower_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic clock,
   input  logic reset_n,
   upower_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [15:0] perf_flushed
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_pc, w_pc_nxt;
   logic          r_req, w_req_nxt;
   logic [31:0]   r_addr, w_addr_nxt;
   logic [31:0]   r_fifo_data [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_ack, w_pop, w_push;
   logic [CW-1:0] w_count_after;

   assign w_ack         = r_req & bus.imem_ack;
   assign w_pop         = (r_count != '0) & bus.inst_ready;
   assign w_count_after = r_count - CW'(w_pop);

   assign bus.imem_req   = r_req;
   assign bus.imem_addr  = r_addr;
   assign bus.inst_valid = (r_count != '0);
   assign bus.inst_data  = r_fifo_data[r_rd_ptr];
   assign bus.inst_pc    = r_fifo_pc[r_rd_ptr];

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_push      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!bus.redirect_valid && (w_count_after < DEPTH_C)) begin
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_pc;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            // In FETCH r_addr always equals r_pc, so pc+4 is also the next address.
            if (bus.redirect_valid) begin
               if (w_ack) begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DROP;
               end
            end else if (w_ack) begin
               w_push   = 1'b1;
               w_pc_nxt = r_pc + 32'd4;
               if ((w_count_after + CW'(1)) < DEPTH_C) begin
                  w_addr_nxt = r_pc + 32'd4;
               end else begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = IDLE;
               end
            end
         end
         DROP: begin
            if (w_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
      if (bus.redirect_valid) begin
         w_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_req    <= 1'b0;
         r_addr   <= RESET_PC;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_pc[i]   <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= w_addr_nxt;
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
         end
         if (bus.redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= w_count_after + CW'(w_push);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [15:0] r_perf_flushed;
   logic [16:0] w_flush_sum;

   // Discarded entries exclude a coincident pop; a request in FETCH is lost too.
   assign w_flush_sum = {1'b0, r_perf_flushed} + 17'(w_count_after)
                      + 17'(r_state == FETCH);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_fetched <= '0;
         r_perf_flushed <= '0;
      end else begin
         if (w_push && (r_perf_fetched != '1)) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (bus.redirect_valid) begin
            r_perf_flushed <= w_flush_sum[16] ? '1 : w_flush_sum[15:0];
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif
endmodule

// File: doc/upower_fetch_unit.md
Name: upower_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the uPower core's decode stage.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch redirects from the execute stage and flushes all in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, level-held until acked.
- imem_addr  out  32  fetch address, word aligned, stable while imem_req=1.
- imem_ack  in  1  memory accepts request and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_req&imem_ack.
- redirect_valid  in  1  branch taken / flush request, one-cycle pulse.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- inst_valid  out  1  FIFO head valid to decode.
- inst_data  out  32  instruction at FIFO head.
- inst_pc  out  32  PC of instruction at FIFO head.
- inst_ready  in  1  decode accepts head this cycle.

Behaviour:
- Clocking and reset: one clock (clock); reset_n is asynchronous and active-low.
- Reset values (immediate on reset_n=0, any state):
  - pc=RESET_PC, FIFO empty, state IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0.
- Reset mid-fetch abandons the outstanding request without waiting for ack.
- FIFO:
  - inst_valid = FIFO not empty; inst_data and inst_pc come from head storage.
  - A pop occurs when inst_valid&inst_ready.
  - A push occurs when imem_req&imem_ack in state FETCH.
  - Push and pop in the same cycle are both honoured.
  - Free space for issue = FIFO_DEPTH - count, counting the same-cycle pop and push.
- imem_req and imem_addr are registered. Once imem_req=1, imem_req and imem_addr must not change until the ack cycle; only reset clears them early.
- States:
  - IDLE: if free space >= 1 and no redirect, assert imem_req with imem_addr=pc next cycle -> FETCH.
  - FETCH: hold the request.
    - On ack with no redirect: push {pc, imem_rdata}; pc<=pc+4.
    - If space remains after the push, keep imem_req=1 with imem_addr=pc+4 (back-to-back, 1 instr/cycle with zero-wait memory); otherwise drop imem_req -> IDLE.
  - DROP: a request is outstanding but stale. Hold imem_req until ack, discard imem_rdata, then -> IDLE (reissue at current pc on the following cycle if space).
- Redirect has the highest priority:
  - FIFO is flushed (inst_valid=0 next cycle) and pc<=redirect_pc & ~3.
  - In FETCH without ack: -> DROP.
  - In FETCH with ack in the same cycle: data discarded, no pc+4, -> IDLE.
  - In DROP: pc updated, remain DROP; also discards the ack if coincident.
  - Coincident pop: decode's transfer is complete, then the flush applies.
- imem_ack may assert in the same cycle imem_req rises; latency from ack to inst_valid is 1 cycle.
- PC arithmetic: 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 with no flag.
- imem_ack while imem_req=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (increments on each FIFO push) and perf_flushed[15:0] (increments by the number of FIFO entries discarded plus 1 if a request was dropped, on each redirect).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: no counter logic and no such ports.

Test Plan:
- Reset, zero-wait memory (ack=req, rdata=addr^32'hA5A5_0000), inst_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; inst_pc 0,4,8 one cycle after each ack; inst_data=0xA5A5_0000, 0xA5A5_0004, ...
- inst_ready=0, zero-wait memory -> exactly 4 pushes (pc 0x0..0xC), imem_req=0 with pc=0x10 and FIFO full; raise inst_ready -> fetch resumes at 0x10, no loss or duplication.
- Memory ack delayed 3 cycles; redirect to 0x100 one cycle after req -> request at 0x0 held until ack, data discarded, next imem_addr=0x100, first inst_pc=0x100.
- Redirect to 0x200 in the same cycle as ack of 0x8, with 2 entries buffered -> inst_valid=0 next cycle, 0x8 data never appears, next fetch address 0x200.
- Redirect to 0xFFFF_FFF9 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; inst_pc follows the same order.
- reset_n low mid-FETCH between clock edges -> imem_req=0, inst_valid=0 immediately; after release, first fetch at RESET_PC.
